lvds_tx_link_ctrl: RTL
======================

Name: lvds_tx_link_ctrl

Overview:
- Transmit-side link sequencer for the LVDS SerDes stream path.
- Drives an external combinational 8b/10b encoder instance (9-bit {K,byte} input, running-disparity in/out) and owns the running-disparity register.
- Performs link alignment, K28.5 idle fill, SOF/EOF framing of a byte stream, and periodic comma insertion.
- Emits one registered 10-bit symbol per clock to the serializer.

Parameters:
- ALIGN_COUNT, 64: K28.5 symbols sent after enable before link_up asserts (>=1).
- COMMA_PERIOD, 256: maximum symbols between consecutive K28.5 symbols (>=4).

Ports:
- clk  in  1  symbol clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  link enable
- s_tdata  in  8  payload byte
- s_tvalid  in  1  payload valid
- s_tlast  in  1  last byte of frame
- s_tready  out  1  payload accepted when s_tvalid & s_tready
- enc_datain  out  9  {k, byte} to encoder
- enc_dispin  out  1  running disparity to encoder (0 = RD-, 1 = RD+)
- enc_dataout  in  10  encoder symbol {j,h,g,f,i,e,d,c,b,a}
- enc_dispout  in  1  encoder disparity out
- tx_symbol  out  10  registered symbol to serializer
- tx_valid  out  1  tx_symbol valid
- link_up  out  1  alignment complete
- rd  out  1  current running disparity

Behaviour:
- Reset values: tx_symbol=0, tx_valid=0, link_up=0, rd=0, s_tready=0, state=OFF, comma counter=0, align counter=0.
- enc_dispin=rd at all times. Each cycle a symbol is selected and tx_valid is set: tx_symbol<=enc_dataout and rd<=enc_dispout on that edge. Latency from selection to tx_symbol is 1 clk.
- Symbol codes (enc_datain):
  - K28.5 = 9'h1BC
  - SOF K27.7 = 9'h1FB
  - EOF K29.7 = 9'h1FD
  - data = {1'b0, s_tdata}
- States:
  - OFF: no symbol, tx_valid<=0. enable=1 -> ALIGN.
  - ALIGN: send K28.5 each cycle. After ALIGN_COUNT symbols -> IDLE, link_up<=1.
  - IDLE: send K28.5 and clear the comma counter. s_tvalid=1 -> SOF, else stay.
  - SOF: send K27.7 -> DATA.
  - DATA:
    - s_tready = ~comma_due.
    - On accept, send the data byte. Accept with s_tlast=1 -> EOF.
    - s_tvalid=0 or comma_due: send K28.5 filler and stay in frame.
  - EOF: send K29.7 -> IDLE.
- Comma counter:
  - Increments on every non-K28.5 symbol and clears on every K28.5.
  - comma_due = (counter == COMMA_PERIOD-1). The next symbol is then forced to K28.5 in any state.
  - SOF and EOF slots are delayed by one cycle when they coincide with comma_due.
- s_tready is combinational from state and counter. It is 0 outside DATA.
- enable deasserted in any state: next state OFF; link_up<=0; s_tready=0 immediately; counters clear; any open frame is aborted with no EOF; rd is held.
- Async rst mid-frame: all outputs go to reset values immediately; the frame is lost.
- Simultaneous s_tvalid and comma_due in DATA: the comma wins; the byte is held by the source (not accepted).

Optional Feature:
- Macro LVDS_TX_PRBS_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - In IDLE with test_mode=1 and link_up, go to state TEST.
  - TEST sends data bytes {0, prbs[7:0]} from a PRBS-7 generator (x^7+x^6+1, seed 7'h7F at reset and on TEST entry). The generator advances 8 bits per sent byte.
  - Comma insertion still applies; s_tready=0.
  - test_mode=0 -> IDLE.
- Undefined: no port, no TEST state; behaviour identical to test_mode=0.

Test Plan:
- rst pulse, enable=1, ALIGN_COUNT=4: tx_symbol alternates 10'h17C/10'h283 (K28.5 RD-/RD+) for 4 cycles from rd=0; then link_up=1 and rd toggles each K28.5.
- After link_up, 3-byte frame 8'h01,8'h02,8'h03 (tlast on 3rd) with s_tvalid held: symbols are K27.7, D1.0, D2.0, D3.0, K29.7, then K28.5. s_tready is high for exactly 3 cycles. rd equals the encoder's dispout chain.
- COMMA_PERIOD=8, continuous 20-byte frame: no run exceeds 7 non-K28.5 symbols. s_tready drops for exactly one cycle at each forced comma, and no byte is lost or duplicated.
- s_tvalid gap of 2 cycles mid-frame: two K28.5 fillers are sent and the frame stays open. EOF follows only the tlast byte.
- enable=0 during DATA: next cycle tx_valid=0, link_up=0, s_tready=0, no EOF sent. Re-enable restarts ALIGN with ALIGN_COUNT commas.
- LVDS_TX_PRBS_EN defined, test_mode=1 in IDLE: the first payload bytes match the PRBS-7 reference from seed 7'h7F. Commas appear every COMMA_PERIOD symbols, and s_tready stays 0.

Source files
------------

// File: rtl/lvds_tx_link_ctrl_if.sv
// ---------------------------------------------------------------------------
// lvds_tx_link_ctrl_if
//   Bundles the payload stream, the external 8b/10b encoder hookup and the
//   serializer-facing symbol outputs of lvds_tx_link_ctrl.
//
//   Signals:
//     s_tdata[7:0], s_tvalid, s_tlast  payload byte stream (source -> ctrl)
//     s_tready                         payload accepted on s_tvalid & s_tready
//     enc_datain[8:0]                  {k, byte} presented to the encoder
//     enc_dispin                       running disparity to the encoder
//     enc_dataout[9:0]                 encoder symbol {j,h,g,f,i,e,d,c,b,a}
//     enc_dispout                      encoder disparity out
//     tx_symbol[9:0], tx_valid         registered symbol to the serializer
//     link_up                          alignment complete
//     rd                               current running disparity
//
//   Modports:
//     master  the link controller itself
//     slave   the environment (payload source, encoder, serializer)
// ---------------------------------------------------------------------------
interface lvds_tx_link_ctrl_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [8:0] enc_datain;
  logic       enc_dispin;
  logic [9:0] enc_dataout;
  logic       enc_dispout;
  logic [9:0] tx_symbol;
  logic       tx_valid;
  logic       link_up;
  logic       rd;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, enc_dataout, enc_dispout,
    output s_tready, enc_datain, enc_dispin, tx_symbol, tx_valid, link_up, rd
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, enc_dataout, enc_dispout,
    input  s_tready, enc_datain, enc_dispin, tx_symbol, tx_valid, link_up, rd
  );
endinterface

// File: rtl/lvds_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// lvds_tx_link_ctrl
//   Transmit-side link sequencer for the LVDS SerDes stream path. Selects one
//   {K, byte} code per clock for an external combinational 8b/10b encoder,
//   owns the running-disparity register, and registers the encoded symbol
//   for the serializer. Handles link alignment (K28.5 burst), K28.5 idle
//   fill, SOF (K27.7) / EOF (K29.7) framing and periodic comma insertion.
//
//   Ports:
//     clk        symbol clock
//     rst        asynchronous reset, active-high
//     enable     link enable; low forces OFF and aborts any open frame
//     test_mode  (only with LVDS_TX_PRBS_EN) send PRBS-7 payload from IDLE
//     bus        lvds_tx_link_ctrl_if.master (stream, encoder, tx outputs)
//
//   Parameters:
//     ALIGN_COUNT   K28.5 symbols sent after enable before link_up (>=1)
//     COMMA_PERIOD  max symbols between consecutive K28.5 symbols (>=4)
//
//   Optional feature macro: LVDS_TX_PRBS_EN adds the test_mode port and a
//   TEST state streaming PRBS-7 (x^7+x^6+1) bytes, 8 bits per byte, MSB is
//   the earliest generated bit.
// ---------------------------------------------------------------------------
module lvds_tx_link_ctrl #(
  parameter int ALIGN_COUNT  = 64,
  parameter int COMMA_PERIOD = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef LVDS_TX_PRBS_EN
  input  logic                  test_mode,
`endif
  lvds_tx_link_ctrl_if.master   bus
);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_SOF   = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_EOF   = 3'd5;
`ifdef LVDS_TX_PRBS_EN
  localparam logic [2:0] ST_TEST  = 3'd6;
`endif

  localparam logic [8:0] K28_5 = 9'h1BC;
  localparam logic [8:0] K27_7 = 9'h1FB;
  localparam logic [8:0] K29_7 = 9'h1FD;

  localparam int CW = $clog2(COMMA_PERIOD);
  localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] comma_cnt;
  logic [AW-1:0] align_cnt;
  logic          comma_due;
  logic          sym_vld;
  logic [8:0]    sym_code;
  logic          ready;

`ifdef LVDS_TX_PRBS_EN
  logic [6:0]  prbs;
  logic [14:0] prbs_step;
  logic        prbs_seed;
  logic        prbs_adv;

  // Advance the PRBS-7 register by eight shifts; returns {next_state, byte}
  // with the first generated bit in byte[7].
  function automatic logic [14:0] prbs_next8(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] b;
    logic       fb;
    st = s;
    b  = '0;
    for (int i = 0; i < 8; i++) begin
      fb = st[6] ^ st[5];
      b  = {b[6:0], fb};
      st = {st[5:0], fb};
    end
    return {st, b};
  endfunction

  assign prbs_step = prbs_next8(prbs);
`endif

  // ---- symbol selection (comb) -> registered symbol / disparity ----------
  always_comb begin
    comma_due = (comma_cnt == COMMA_LAST);
    state_nxt = state;
    sym_vld   = 1'b1;
    sym_code  = K28_5;
    ready     = 1'b0;
`ifdef LVDS_TX_PRBS_EN
    prbs_seed = 1'b0;
    prbs_adv  = 1'b0;
`endif
    if (!enable) begin
      state_nxt = ST_OFF;
      sym_vld   = 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          sym_vld   = 1'b0;
          state_nxt = ST_ALIGN;
        end
        ST_ALIGN: begin
          if (align_cnt == ALIGN_LAST) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
`ifdef LVDS_TX_PRBS_EN
          if (test_mode && bus.link_up) begin
            state_nxt = ST_TEST;
            prbs_seed = 1'b1;
          end else if (bus.s_tvalid) begin
            state_nxt = ST_SOF;
          end
`else
          if (bus.s_tvalid) state_nxt = ST_SOF;
`endif
        end
        // SOF/EOF slip one cycle when a comma is due.
        ST_SOF: begin
          if (!comma_due) begin
            sym_code  = K27_7;
            state_nxt = ST_DATA;
          end
        end
        // A due comma outranks a pending byte; the source holds it.
        ST_DATA: begin
          ready = ~comma_due;
          if (!comma_due && bus.s_tvalid) begin
            sym_code = {1'b0, bus.s_tdata};
            if (bus.s_tlast) state_nxt = ST_EOF;
          end
        end
        ST_EOF: begin
          if (!comma_due) begin
            sym_code  = K29_7;
            state_nxt = ST_IDLE;
          end
        end
`ifdef LVDS_TX_PRBS_EN
        ST_TEST: begin
          if (!test_mode) begin
            state_nxt = ST_IDLE;
          end else if (!comma_due) begin
            sym_code = {1'b0, prbs_step[7:0]};
            prbs_adv = 1'b1;
          end
        end
`endif
        default: begin
          sym_vld   = 1'b0;
          state_nxt = ST_OFF;
        end
      endcase
    end
  end

  assign bus.s_tready   = ready;
  assign bus.enc_datain = sym_code;
  assign bus.enc_dispin = bus.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OFF;
      comma_cnt     <= '0;
      align_cnt     <= '0;
      bus.tx_symbol <= '0;
      bus.tx_valid  <= 1'b0;
      bus.link_up   <= 1'b0;
      bus.rd        <= 1'b0;
`ifdef LVDS_TX_PRBS_EN
      prbs          <= 7'h7F;
`endif
    end else begin
      state        <= state_nxt;
      bus.tx_valid <= sym_vld;
      // Disparity is held whenever no symbol goes out (OFF / disabled).
      if (sym_vld) begin
        bus.tx_symbol <= bus.enc_dataout;
        bus.rd        <= bus.enc_dispout;
      end
      if (!enable) begin
        bus.link_up <= 1'b0;
        comma_cnt   <= '0;
        align_cnt   <= '0;
      end else begin
        if (state == ST_ALIGN && align_cnt == ALIGN_LAST) bus.link_up <= 1'b1;
        if (state == ST_ALIGN && align_cnt != ALIGN_LAST)
          align_cnt <= align_cnt + 1'b1;
        else
          align_cnt <= '0;
        if (!sym_vld || sym_code == K28_5)
          comma_cnt <= '0;
        else
          comma_cnt <= comma_cnt + 1'b1;
      end
`ifdef LVDS_TX_PRBS_EN
      if (prbs_seed)
        prbs <= 7'h7F;
      else if (prbs_adv)
        prbs <= prbs_step[14:8];
`endif
    end
  end

endmodule
